// File: rtl/jtframe_avatar_arb_pkg.sv
// Shared encodings for the avatar/game object-ROM slot arbiter.
package jtframe_avatar_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam logic PORT_G = 1'b0;
  localparam logic PORT_A = 1'b1;
endpackage

// File: rtl/jtframe_avatar_arb_port.sv
// One requester side: data/last-address/valid latches plus pending and ok.
module jtframe_avatar_arb_port #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          take,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   rom_data,
  output logic          pend,
  output logic          ok,
  output logic [15:0]   data
);
  logic [15:0]   data_q;
  logic [AW-1:0] last_q;
  logic          vld_q;
  logic          hit;

  assign ok   = vld_q & cs & (addr == last_q);
  assign pend = cs & ((addr != last_q) | ~ok);
  assign data = data_q;
  // Data is only accepted if the requester still wants the address that was sent.
  assign hit  = take & cs & (addr == req_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      last_q <= '0;
      vld_q  <= 1'b0;
    end else if (hit) begin
      data_q <= rom_data;
      last_q <= addr;
      vld_q  <= 1'b1;
    end else begin
      // Once ok has dropped, returning to the old address must refetch.
      vld_q  <= vld_q & ok;
    end
  end
endmodule

// File: rtl/jtframe_avatar_arb.sv
// Shares one object-ROM slot between the game fetcher (G) and avatar fetcher (A).
module jtframe_avatar_arb
  import jtframe_avatar_arb_pkg::*;
#(
  parameter int AW     = 13,
  parameter int STARVE = 4,
  parameter int TOUT   = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pause,
  input  logic          g_cs,
  input  logic [AW-1:0] g_addr,
  output logic          g_ok,
  output logic [15:0]   g_data,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  output logic          a_ok,
  output logic [15:0]   a_data,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ok,
  input  logic [15:0]   rom_data,
  output logic          tout_err
);
  localparam int SW = $clog2(STARVE + 1);
  localparam int TW = $clog2(TOUT + 1);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE);
  localparam logic [TW-1:0] TOUT_C   = TW'(TOUT);

  state_t        state_q;
  logic          gnt_q, rom_cs_q, tout_err_q;
  logic [AW-1:0] rom_addr_q;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tout_q;
  logic          g_pend, a_pend, take_g, take_a;
  logic          prio, prio_pend, oth_pend, win;

  assign take_g = (state_q == BUSY) & rom_ok & (gnt_q == PORT_G);
  assign take_a = (state_q == BUSY) & rom_ok & (gnt_q == PORT_A);

  jtframe_avatar_arb_port #(.AW(AW)) u_g (
    .clk(clk), .rst_n(rst_n), .cs(g_cs), .addr(g_addr), .take(take_g),
    .req_addr(rom_addr_q), .rom_data(rom_data), .pend(g_pend), .ok(g_ok), .data(g_data)
  );

  jtframe_avatar_arb_port #(.AW(AW)) u_a (
    .clk(clk), .rst_n(rst_n), .cs(a_cs), .addr(a_addr), .take(take_a),
    .req_addr(rom_addr_q), .rom_data(rom_data), .pend(a_pend), .ok(a_ok), .data(a_data)
  );

  always_comb begin
    prio      = pause ? PORT_A : PORT_G;
    prio_pend = pause ? a_pend : g_pend;
    oth_pend  = pause ? g_pend : a_pend;
    win       = prio;
    starve_d  = '0;
    if (prio_pend && oth_pend) begin
      // After STARVE back-to-back wins the waiting port gets one turn.
      if (starve_q == STARVE_C) win = ~prio;
      else                      starve_d = starve_q + 1'b1;
    end else if (oth_pend) begin
      win = ~prio;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= PORT_G;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      starve_q   <= '0;
      tout_q     <= '0;
      tout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (g_pend || a_pend) begin
          gnt_q      <= win;
          rom_addr_q <= (win == PORT_A) ? a_addr : g_addr;
          rom_cs_q   <= 1'b1;
          starve_q   <= starve_d;
          tout_q     <= '0;
          state_q    <= BUSY;
        end
        BUSY: begin
          if (tout_q != TOUT_C) tout_q <= tout_q + 1'b1;
          if (rom_ok) begin
            rom_cs_q <= 1'b0;
            state_q  <= IDLE;
          end else if (tout_q == TOUT_C) begin
            rom_cs_q   <= 1'b0;
            tout_err_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign tout_err = tout_err_q;
endmodule

// File: tb/tb_jtframe_avatar_arb.sv
// Directed bench for the object-ROM slot arbiter.
module tb_jtframe_avatar_arb;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n, pause, g_cs, a_cs, rom_ok;
  logic [AW-1:0] g_addr, a_addr;
  logic          g_ok, a_ok, rom_cs, tout_err;
  logic [15:0]   g_data, a_data, rom_data;
  logic [AW-1:0] rom_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jtframe_avatar_arb #(.AW(AW), .STARVE(4), .TOUT(63)) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause),
    .g_cs(g_cs), .g_addr(g_addr), .g_ok(g_ok), .g_data(g_data),
    .a_cs(a_cs), .a_addr(a_addr), .a_ok(a_ok), .a_data(a_data),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data),
    .tout_err(tout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20 && rom_cs !== 1'b1; i++) tick();
    chk("grant_wait", rom_cs, 1);
  endtask

  logic exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    rst_n = 0; pause = 0; g_cs = 1; a_cs = 1; rom_ok = 0; rom_data = '0;
    g_addr = 13'h0040; a_addr = 13'h0080;
    repeat (3) tick();
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_g_ok", g_ok, 0);
    chk("rst_a_ok", a_ok, 0);
    chk("rst_g_data", g_data, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_tout_err", tout_err, 0);
    g_cs = 0; a_cs = 0; rst_n = 1;
    tick();

    // single grant
    g_cs = 1; g_addr = 13'h0123;
    tick();
    chk("sg_rom_cs", rom_cs, 1);
    chk("sg_rom_addr", rom_addr, 13'h0123);
    tick(); tick();
    rom_ok = 1; rom_data = 16'hBEEF;
    tick();
    rom_ok = 0;
    chk("sg_g_ok", g_ok, 1);
    chk("sg_g_data", g_data, 16'hBEEF);
    chk("sg_cs_drop", rom_cs, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sg_no_refetch", rom_cs, 0);
    end
    chk("sg_ok_held", g_ok, 1);
    g_addr = 13'h0124; #1;
    chk("sg_ok_addr_drop", g_ok, 0);
    g_cs = 0; g_addr = 13'h0123; #1;
    chk("sg_ok_cs_drop", g_ok, 0);
    tick();

    // address change in flight
    g_cs = 1; g_addr = 13'h0010;
    tick();
    chk("ac_rom_addr0", rom_addr, 13'h0010);
    g_addr = 13'h0011;
    tick();
    rom_ok = 1; rom_data = 16'hAAAA;
    tick();
    rom_ok = 0;
    chk("ac_g_ok", g_ok, 0);
    chk("ac_g_data_kept", g_data, 16'hBEEF);
    chk("ac_idle", rom_cs, 0);
    tick();
    chk("ac_reissue_cs", rom_cs, 1);
    chk("ac_reissue_addr", rom_addr, 13'h0011);
    rom_ok = 1; rom_data = 16'h1111;
    tick();
    rom_ok = 0;
    chk("ac_g_ok2", g_ok, 1);
    chk("ac_g_data2", g_data, 16'h1111);

    // priority and starvation
    pause = 1; g_addr = 13'h0100; a_addr = 13'h0800; a_cs = 1;
    for (int k = 0; k < 10; k++) begin
      wait_grant();
      chk($sformatf("order%0d", k), (rom_addr == a_addr), exp_order[k]);
      if (rom_addr == a_addr) a_addr = a_addr + 1'b1;
      else                    g_addr = g_addr + 1'b1;
      rom_ok = 1; rom_data = 16'h2222;
      tick();
      rom_ok = 0;
    end

    // timeout
    pause = 0; a_cs = 0; g_cs = 1; g_addr = 13'h0055;
    tick();
    chk("to_rise", rom_cs, 1);
    chk("to_addr", rom_addr, 13'h0055);
    repeat (63) tick();
    chk("to_still_busy", rom_cs, 1);
    chk("to_no_err_yet", tout_err, 0);
    tick();
    chk("to_fall", rom_cs, 0);
    chk("to_err", tout_err, 1);
    chk("to_unserved", g_ok, 0);
    tick();
    chk("to_rereq", rom_cs, 1);
    chk("to_rereq_addr", rom_addr, 13'h0055);
    rom_ok = 1; rom_data = 16'h5555;
    tick();
    rom_ok = 0;
    chk("to_served", g_data, 16'h5555);
    chk("to_err_sticky", tout_err, 1);

    // reset mid-transaction
    g_addr = 13'h0066;
    tick();
    chk("rm_busy", rom_cs, 1);
    rst_n = 0; g_cs = 0; a_cs = 0; rom_ok = 1; rom_data = 16'h7777;
    tick();
    rom_ok = 0;
    chk("rm_rom_cs", rom_cs, 0);
    chk("rm_g_data", g_data, 0);
    chk("rm_err_clr", tout_err, 0);
    rst_n = 1;
    tick();
    rom_ok = 1;
    tick();
    rom_ok = 0;
    chk("rm_g_ok", g_ok, 0);
    chk("rm_a_ok", a_ok, 0);
    chk("rm_rom_cs2", rom_cs, 0);
    chk("rm_g_data2", g_data, 0);
    chk("rm_a_data2", a_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jtframe_avatar_arb.md
Name: jtframe_avatar_arb

Overview:
- Arbitrates one shared object-ROM/SDRAM read slot between two requesters: the game object fetcher (port G) and the avatar fetcher (port A).
- Sits between the object engine / avatar sequencer and the SDRAM slot. Its outputs feed the pause-time object mux.
- Priority follows `pause`, with an anti-starvation counter, a transaction timeout and per-port data latches.

Parameters:
- AW, 13, address width of both requesters and the ROM slot.
- STARVE, 4, maximum consecutive grants to the priority port while the other port is pending.
- TOUT, 63, cycles to wait for rom_ok before aborting a transaction.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- pause  in  1  1 = avatar port has priority; 0 = game port has priority
- g_cs  in  1  game request
- g_addr  in  AW  game address
- g_ok  out  1  game data valid for current g_addr
- g_data  out  16  game data
- a_cs  in  1  avatar request
- a_addr  in  AW  avatar address
- a_ok  out  1  avatar data valid for current a_addr
- a_data  out  16  avatar data
- rom_cs  out  1  slot request
- rom_addr  out  AW  slot address
- rom_ok  in  1  slot data valid (single-cycle pulse)
- rom_data  in  16  slot data
- tout_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: g_ok=a_ok=rom_cs=tout_err=0; g_data=a_data=0; rom_addr=0.
  - State: IDLE, starvation counter=0, timeout counter=0, last-address registers=0.
  - Reset mid-transaction discards the transaction; any rom_ok arriving later is ignored because the state is IDLE.
- Port pending: cs=1 and (addr differs from that port's last-served address, or the port's ok=0).
- Ok rules:
  - A port's ok drops in the same cycle that its addr changes or its cs goes low. This is a combinational compare against the latched address, gated by a registered valid bit.
  - Ok stays high while cs=1 and addr is unchanged; data is held.
- IDLE state:
  - If any port is pending, pick the winner, register rom_addr and rom_cs=1 on the next edge, and go to BUSY.
  - Winner when both are pending: the priority port (A if pause=1, else G).
  - Exception: if starvation counter==STARVE, the other port wins and the counter clears.
  - The counter increments when the priority port wins while the other port is pending. It clears when the other port is granted or is not pending.
  - A lone pending port always wins.
- BUSY state: rom_cs held at 1, rom_addr stable, timeout counter increments each cycle.
  - rom_ok=1 and the granted port still has cs=1 and the same addr: latch rom_data into that port's data register and last-address register, set its valid bit, so ok=1 from the next cycle. rom_cs=0, go to IDLE.
  - rom_ok=1 but the granted port's addr changed or cs dropped: discard the data, rom_cs=0, go to IDLE (the port re-arbitrates).
  - Timeout counter==TOUT without rom_ok: rom_cs=0, set tout_err=1, leave the port not served, go to IDLE.
  - tout_err clears only on reset.
- Latency:
  - Request-to-rom_cs: 1 cycle from IDLE.
  - rom_ok-to-port ok: 1 cycle.
  - Minimum one IDLE cycle between transactions (rom_cs deasserts for at least 1 cycle).
- Simultaneous events:
  - rom_ok in the same cycle as rst_n=0: reset wins.
  - pause toggling during BUSY does not affect the current transaction; it only affects the next arbitration.
  - cs and addr change on the winner in the grant cycle: the new addr is sampled in the next arbitration.
- Width rules: counters are saturating, sized ceil(log2(TOUT+1)) and ceil(log2(STARVE+1)). The addr compare is full AW bits.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, BUSY=1'b1) and port index constants (PORT_G=0, PORT_A=1).
- Sub-module jtframe_avatar_arb_port, instantiated twice: holds data, last-address and valid registers and computes pending/ok.
- Arbitration FSM, starvation and timeout counters live at top level.

Test Plan:
- Reset: hold rst_n=0 with g_cs=a_cs=1 -> rom_cs=0, g_ok=a_ok=0, g_data=a_data=0.
- Single grant: pause=0, g_cs=1, g_addr=0x0123, rom_ok pulsed 3 cycles after rom_cs with rom_data=0xBEEF -> rom_addr=0x0123; g_ok=1 and g_data=0xBEEF one cycle later; no new rom_cs while g_addr is unchanged.
- Priority and starvation: pause=1, both ports continuously changing addr each grant, STARVE=4 -> grant order A,A,A,A,G,A,A,A,A,G.
- Address change in flight: g_addr changes 0x10 -> 0x11 while BUSY, rom_ok returns 0xAAAA -> g_ok stays 0; a second transaction is issued at 0x11.
- Timeout: rom_ok never asserted, TOUT=63 -> rom_cs falls 64 cycles after rising, tout_err=1 sticky, port re-requests next cycle.
- Reset mid-transaction: rst_n=0 while BUSY, then rom_ok pulses after reset -> g_ok=a_ok=0, rom_cs=0, no data latched.
